// File: rtl/n64_snac_multi.sv
// n64_snac_multi: multi-port Joybus host transceiver for SNAC pads.
// Sends 1..63 command bytes to one pad line and receives 0..63 reply bytes.
//
// Ports:
//   clk_1x, reset_n        clock, async active-low reset
//   start, port_sel        begin transaction on the selected pad line
//   tx_len, rx_len         command / reply byte counts, latched on start
//   tx_data/valid/ready    command byte stream (valid/ready)
//   rx_data, rx_valid      reply byte and its one-cycle strobe
//   rx_count               reply bytes received in current/last transaction
//   busy, done, timeout    status; done/timeout are one-cycle pulses
//   joy_in, joy_out        pad lines; joy_out 0 = pull low, 1 = release
//
// Optional: define JOYBUS_GLITCH_FILTER_EN to add a 3-sample majority
// filter on the received line (2 cycles latency, rejects 1-cycle lows).

module n64_snac_multi #(
    parameter int NUM_PORTS  = 4,
    parameter int CLK_PER_US = 64,
    parameter int TIMEOUT_US = 16,
    parameter int SETTLE_CYC = 20,
    localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk_1x,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [PORT_W-1:0]    port_sel,
    input  logic [5:0]           tx_len,
    input  logic [5:0]           rx_len,
    input  logic [7:0]           tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    output logic [5:0]           rx_count,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    input  logic [NUM_PORTS-1:0] joy_in,
    output logic [NUM_PORTS-1:0] joy_out
);

    localparam int BIT_SHORT = CLK_PER_US;
    localparam int BIT_LONG  = 3 * CLK_PER_US;
    localparam int LW_SAT    = 3 * CLK_PER_US + 1;
    localparam int LW_THR    = 2 * CLK_PER_US;
    localparam int TO_CYC    = TIMEOUT_US * CLK_PER_US;
    localparam int CNT_MAX   = (BIT_LONG > SETTLE_CYC) ? BIT_LONG : SETTLE_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int LW_W      = $clog2(LW_SAT + 1);
    localparam int TO_W      = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_TX_LOW,
        S_TX_HIGH,
        S_STOP_LOW,
        S_SETTLE,
        S_RX,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PORT_W-1:0]   port_q, port_d;
    logic [5:0]          tx_rem_q, tx_rem_d;
    logic [5:0]          rx_len_q, rx_len_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic [7:0]          sh_q, sh_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic [5:0]          rx_count_q, rx_count_d;
    logic                rx_valid_q, rx_valid_d;
    logic [NUM_PORTS-1:0] joy_out_q, joy_out_d;
    logic                drive_d;

    logic                s1_q, s2_q, prev_q;
    logic                line_cur;
    logic [LW_W-1:0]     lw_q;
    logic                fall, rise, rx_bit;
    int                  lo_w, hi_w;

`ifdef JOYBUS_GLITCH_FILTER_EN
    logic h0_q, h1_q, filt_q;

    always_ff @(posedge clk_1x or negedge reset_n) begin
        if (!reset_n) begin
            h0_q   <= 1'b1;
            h1_q   <= 1'b1;
            filt_q <= 1'b1;
        end else begin
            h0_q   <= s2_q;
            h1_q   <= h0_q;
            filt_q <= (s2_q & h0_q) | (s2_q & h1_q) | (h0_q & h1_q);
        end
    end

    assign line_cur = filt_q;
`else
    assign line_cur = s2_q;
`endif

    assign fall   = prev_q & ~line_cur;
    assign rise   = ~prev_q & line_cur;
    assign rx_bit = (lw_q < LW_W'(LW_THR));

    assign tx_ready = (state_q == S_FETCH);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_count = rx_count_q;
    assign joy_out  = joy_out_q;

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        tx_rem_d   = tx_rem_q;
        rx_len_d   = rx_len_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_byte_d  = tx_byte_q;
        sh_d       = sh_q;
        to_d       = to_q;
        rx_data_d  = rx_data_q;
        rx_count_d = rx_count_q;
        rx_valid_d = 1'b0;
        timeout    = 1'b0;
        lo_w       = tx_byte_q[7] ? BIT_SHORT : BIT_LONG;
        hi_w       = tx_byte_q[7] ? BIT_LONG : BIT_SHORT;
        // the single FETCH cycle supplies the last high cycle of a byte
        if (bit_q == 3'd7 && tx_rem_q != 6'd0) hi_w = hi_w - 1;

        unique case (state_q)
            S_IDLE: begin
                if (start && tx_len != 6'd0) begin
                    port_d     = port_sel;
                    tx_rem_d   = tx_len;
                    rx_len_d   = rx_len;
                    rx_count_d = 6'd0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                if (tx_valid) begin
                    tx_byte_d = tx_data;
                    tx_rem_d  = tx_rem_q - 6'd1;
                    bit_d     = 3'd0;
                    cnt_d     = '0;
                    state_d   = S_TX_LOW;
                end
            end
            S_TX_LOW: begin
                if (int'(cnt_q) + 1 >= lo_w) begin
                    cnt_d   = '0;
                    state_d = S_TX_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TX_HIGH: begin
                if (int'(cnt_q) + 1 >= hi_w) begin
                    cnt_d     = '0;
                    tx_byte_d = {tx_byte_q[6:0], 1'b0};
                    bit_d     = bit_q + 3'd1;
                    if (bit_q != 3'd7) state_d = S_TX_LOW;
                    else if (tx_rem_q != 6'd0) state_d = S_FETCH;
                    else state_d = S_STOP_LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP_LOW: begin
                if (int'(cnt_q) + 1 >= BIT_SHORT) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (int'(cnt_q) + 1 >= SETTLE_CYC) begin
                    cnt_d = '0;
                    if (rx_len_q == 6'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RX;
                        to_d    = TO_W'(TO_CYC);
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RX: begin
                // an edge always wins over expiry, so a completing byte
                // is delivered even when the counter hits 0 that cycle
                if (rise || fall) begin
                    to_d = TO_W'(TO_CYC);
                    if (rise) begin
                        if (rx_count_q == rx_len_q) begin
                            state_d = S_DONE;
                        end else begin
                            sh_d  = {sh_q[6:0], rx_bit};
                            bit_d = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                rx_data_d  = {sh_q[6:0], rx_bit};
                                rx_valid_d = 1'b1;
                                rx_count_d = rx_count_q + 6'd1;
                            end
                        end
                    end
                end else if (to_q == '0) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // pins are registered from next-state so they line up with state_q
    always_comb begin
        joy_out_d = '1;
        drive_d   = (state_d == S_TX_LOW) || (state_d == S_STOP_LOW);
        for (int i = 0; i < NUM_PORTS; i++) begin
            joy_out_d[i] = !(drive_d && (port_d == PORT_W'(i)));
        end
    end

    always_ff @(posedge clk_1x or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_1x or negedge reset_n) begin
        if (!reset_n) begin
            port_q     <= '0;
            tx_rem_q   <= 6'd0;
            rx_len_q   <= 6'd0;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            tx_byte_q  <= 8'd0;
            sh_q       <= 8'd0;
            to_q       <= '0;
            rx_data_q  <= 8'd0;
            rx_count_q <= 6'd0;
            rx_valid_q <= 1'b0;
            joy_out_q  <= '1;
        end else begin
            port_q     <= port_d;
            tx_rem_q   <= tx_rem_d;
            rx_len_q   <= rx_len_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_byte_q  <= tx_byte_d;
            sh_q       <= sh_d;
            to_q       <= to_d;
            rx_data_q  <= rx_data_d;
            rx_count_q <= rx_count_d;
            rx_valid_q <= rx_valid_d;
            joy_out_q  <= joy_out_d;
        end
    end

    // lw_q ends a low pulse holding its length in cycles (fall cycle = 1)
    always_ff @(posedge clk_1x or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
            lw_q   <= '0;
        end else begin
            s1_q   <= joy_in[port_q];
            s2_q   <= s1_q;
            prev_q <= line_cur;
            if (fall) begin
                lw_q <= LW_W'(1);
            end else if (!line_cur && lw_q != LW_W'(LW_SAT)) begin
                lw_q <= lw_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_n64_snac_multi.sv
// tb_n64_snac_multi: directed bench for n64_snac_multi.
// Pad lines are open-drain: joy_in = joy_out & pad drive.

module tb_n64_snac_multi;

    localparam int NP = 4;

    logic          clk_1x = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    port_sel = 2'd0;
    logic [5:0]    tx_len = 6'd0;
    logic [5:0]    rx_len = 6'd0;
    logic [7:0]    tx_data = 8'd0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [5:0]    rx_count;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [NP-1:0] joy_in;
    logic [NP-1:0] joy_out;
    logic [NP-1:0] pad_drv = '1;

    int total = 0;
    int bad = 0;
    int stuck = 0;

    assign joy_in = joy_out & pad_drv;

    n64_snac_multi #(
        .NUM_PORTS(NP), .CLK_PER_US(64), .TIMEOUT_US(16), .SETTLE_CYC(20)
    ) dut (
        .clk_1x(clk_1x), .reset_n(reset_n), .start(start),
        .port_sel(port_sel), .tx_len(tx_len), .rx_len(rx_len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count),
        .busy(busy), .done(done), .timeout(timeout),
        .joy_in(joy_in), .joy_out(joy_out)
    );

    always #5 clk_1x = ~clk_1x;

    // line run-length recorder and pulse counters
    int         mon_port = 0;
    bit         mon_on = 1'b0;
    logic       mon_lvl = 1'b1;
    int         mon_run = 0;
    int         seg_len[$];
    logic       seg_lvl[$];
    logic [7:0] rx_q[$];
    int         done_cnt = 0;
    int         to_cnt = 0;
    int         other_low = 0;

    always @(negedge clk_1x) begin
        if (joy_out[mon_port] !== mon_lvl) begin
            if (mon_on) begin
                seg_len.push_back(mon_run);
                seg_lvl.push_back(mon_lvl);
            end
            mon_lvl = joy_out[mon_port];
            mon_run = 1;
        end else begin
            mon_run++;
        end
        for (int i = 0; i < NP; i++)
            if (i != mon_port && joy_out[i] !== 1'b1) other_low++;
        if (rx_valid) rx_q.push_back(rx_data);
        if (done) done_cnt++;
        if (timeout) to_cnt++;
    end

    task automatic tick;
        @(negedge clk_1x);
        #1;
    endtask

    task automatic clear_mon(input int p);
        mon_on = 1'b0;
        mon_port = p;
        mon_lvl = joy_out[p];
        mon_run = 0;
        seg_len.delete();
        seg_lvl.delete();
        rx_q.delete();
        done_cnt = 0;
        to_cnt = 0;
        other_low = 0;
        mon_on = 1'b1;
    endtask

    task automatic do_start(input logic [1:0] p, input logic [5:0] tl,
                            input logic [5:0] rl);
        port_sel = p;
        tx_len = tl;
        rx_len = rl;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b, input int stall);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 5000) begin
            tick;
            n++;
        end
        if (n >= 5000) stuck++;
        repeat (stall) tick;
        tx_data = b;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
    endtask

    task automatic wait_segs(input int n);
        int k;
        k = 0;
        while (seg_len.size() < n && k < 20000) begin
            tick;
            k++;
        end
        if (k >= 20000) stuck++;
    endtask

    task automatic pad_bit(input int p, input int lo, input int hi);
        pad_drv[p] = 1'b0;
        repeat (lo) tick;
        pad_drv[p] = 1'b1;
        repeat (hi) tick;
    endtask

    task automatic pad_byte(input int p, input logic [7:0] b);
        for (int i = 7; i >= 0; i--)
            pad_bit(p, b[i] ? 64 : 192, b[i] ? 192 : 64);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick;
        total++; if (joy_out !== 4'hF) begin bad++; $display("FAIL rst_joy_out got=%h want=f", joy_out); end
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL rst_tx_ready got=%b want=0", tx_ready); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b want=0", rx_valid); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b want=0", timeout); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_rx_data got=%h want=00", rx_data); end
        total++; if (rx_count !== 6'd0) begin bad++; $display("FAIL rst_rx_count got=%0d want=0", rx_count); end
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_zero_len;
        do_start(2'd0, 6'd0, 6'd0);
        repeat (3) tick;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_len_busy got=%b want=0", busy); end
    endtask

    task automatic test_tx_only;
        int k;
        clear_mon(0);
        do_start(2'd0, 6'd1, 6'd0);
        feed(8'h00, 0);
        wait_segs(18);
        for (int i = 1; i <= 16; i++) begin
            total++;
            if (seg_lvl[i] !== logic'(i % 2 == 0) ||
                seg_len[i] !== ((i % 2 == 1) ? 192 : 64)) begin
                bad++;
                $display("FAIL tx0_seg%0d got=%b/%0d want=%b/%0d", i, seg_lvl[i],
                         seg_len[i], i % 2 == 0, (i % 2 == 1) ? 192 : 64);
            end
        end
        total++; if (seg_lvl[17] !== 1'b0 || seg_len[17] !== 64) begin bad++; $display("FAIL tx0_stop got=%b/%0d want=0/64", seg_lvl[17], seg_len[17]); end
        k = 0;
        while (done !== 1'b1 && k < 200) begin tick; k++; end
        total++; if (k !== 20) begin bad++; $display("FAIL tx0_settle got=%0d want=20", k); end
        repeat (3) tick;
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL tx0_done_cnt got=%0d want=1", done_cnt); end
        total++; if (other_low !== 0) begin bad++; $display("FAIL tx0_other got=%0d want=0", other_low); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL tx0_busy got=%b want=0", busy); end
    endtask

    task automatic test_reply;
        logic [7:0] exp [3];
        exp[0] = 8'h05; exp[1] = 8'h00; exp[2] = 8'h02;
        clear_mon(0);
        do_start(2'd0, 6'd1, 6'd3);
        feed(8'h00, 0);
        wait_segs(18);
        repeat (30) tick;
        for (int i = 0; i < 3; i++) pad_byte(0, exp[i]);
        pad_bit(0, 64, 64);
        repeat (5) tick;
        total++; if (rx_q.size() !== 3) begin bad++; $display("FAIL rep_nbytes got=%0d want=3", rx_q.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rx_q[i] !== exp[i]) begin bad++; $display("FAIL rep_byte%0d got=%h want=%h", i, rx_q[i], exp[i]); end
        end
        total++; if (rx_count !== 6'd3) begin bad++; $display("FAIL rep_rx_count got=%0d want=3", rx_count); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL rep_done got=%0d want=1", done_cnt); end
        total++; if (to_cnt !== 0) begin bad++; $display("FAIL rep_timeout got=%0d want=0", to_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rep_busy got=%b want=0", busy); end
    endtask

    task automatic test_timeout;
        int k;
        clear_mon(0);
        do_start(2'd0, 6'd1, 6'd4);
        feed(8'h00, 0);
        wait_segs(18);
        k = 0;
        while (timeout !== 1'b1 && k < 3000) begin tick; k++; end
        // 20 settle cycles, then 1024 cycles of silence in RX
        total++; if (k !== 1044) begin bad++; $display("FAIL to_latency got=%0d want=1044", k); end
        tick;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_busy got=%b want=0", busy); end
        total++; if (rx_count !== 6'd0) begin bad++; $display("FAIL to_rx_count got=%0d want=0", rx_count); end
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL to_done got=%0d want=0", done_cnt); end
        total++; if (to_cnt !== 1) begin bad++; $display("FAIL to_count got=%0d want=1", to_cnt); end
    endtask

    task automatic test_width_thresh;
        int k;
        logic [7:0] b;
        b = 8'hA5;
        clear_mon(0);
        do_start(2'd0, 6'd1, 6'd4);
        feed(8'h00, 0);
        wait_segs(18);
        repeat (30) tick;
        for (int i = 7; i >= 0; i--) begin
            if (b[i]) pad_bit(0, 127, 129);
            else pad_bit(0, 128, 128);
        end
        pad_byte(0, 8'h3C);
        k = 0;
        while (timeout !== 1'b1 && k < 3000) begin tick; k++; end
        tick;
        total++; if (rx_q.size() !== 2) begin bad++; $display("FAIL thr_nbytes got=%0d want=2", rx_q.size()); end
        total++; if (rx_q[0] !== 8'hA5) begin bad++; $display("FAIL thr_byte0 got=%h want=a5", rx_q[0]); end
        total++; if (rx_q[1] !== 8'h3C) begin bad++; $display("FAIL thr_byte1 got=%h want=3c", rx_q[1]); end
        total++; if (rx_count !== 6'd2) begin bad++; $display("FAIL thr_rx_count got=%0d want=2", rx_count); end
        total++; if (to_cnt !== 1) begin bad++; $display("FAIL thr_timeout got=%0d want=1", to_cnt); end
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL thr_done got=%0d want=0", done_cnt); end
    endtask

    task automatic test_stall_port2;
        int k;
        int idx;
        int lo;
        int hi;
        logic [7:0] by [3];
        by[0] = 8'h03; by[1] = 8'h80; by[2] = 8'h01;
        clear_mon(2);
        do_start(2'd2, 6'd3, 6'd0);
        feed(by[0], 0);
        feed(by[1], 10);
        feed(by[2], 0);
        wait_segs(50);
        idx = 1;
        for (int n = 0; n < 3; n++) begin
            for (int i = 7; i >= 0; i--) begin
                lo = by[n][i] ? 64 : 192;
                hi = by[n][i] ? 192 : 64;
                if (n == 0 && i == 0) hi = hi + 10;
                total++;
                if (seg_lvl[idx] !== 1'b0 || seg_len[idx] !== lo) begin
                    bad++;
                    $display("FAIL st_lo%0d got=%b/%0d want=0/%0d", idx, seg_lvl[idx], seg_len[idx], lo);
                end
                total++;
                if (seg_lvl[idx+1] !== 1'b1 || seg_len[idx+1] !== hi) begin
                    bad++;
                    $display("FAIL st_hi%0d got=%b/%0d want=1/%0d", idx + 1, seg_lvl[idx+1], seg_len[idx+1], hi);
                end
                idx += 2;
            end
        end
        total++; if (seg_lvl[49] !== 1'b0 || seg_len[49] !== 64) begin bad++; $display("FAIL st_stop got=%b/%0d want=0/64", seg_lvl[49], seg_len[49]); end
        k = 0;
        while (done !== 1'b1 && k < 200) begin tick; k++; end
        tick;
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL st_done got=%0d want=1", done_cnt); end
        total++; if (other_low !== 0) begin bad++; $display("FAIL st_other got=%0d want=0", other_low); end
    endtask

    task automatic test_reset_mid;
        int k;
        clear_mon(1);
        do_start(2'd1, 6'd1, 6'd0);
        feed(8'h00, 0);
        k = 0;
        while (joy_out[1] !== 1'b0 && k < 100) begin tick; k++; end
        repeat (50) tick;
        total++; if (joy_out[1] !== 1'b0) begin bad++; $display("FAIL rm_pre_low got=%b want=0", joy_out[1]); end
        reset_n = 1'b0;
        #1;
        total++; if (joy_out !== 4'hF) begin bad++; $display("FAIL rm_joy_out got=%h want=f", joy_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b want=0", busy); end
        tick;
        reset_n = 1'b1;
        tick;
        total++; if (done_cnt !== 0 || to_cnt !== 0) begin bad++; $display("FAIL rm_pulse got=%0d/%0d want=0/0", done_cnt, to_cnt); end
        clear_mon(1);
        do_start(2'd1, 6'd1, 6'd0);
        feed(8'hFF, 0);
        wait_segs(18);
        total++; if (seg_lvl[1] !== 1'b0 || seg_len[1] !== 64) begin bad++; $display("FAIL rm_bit1 got=%b/%0d want=0/64", seg_lvl[1], seg_len[1]); end
        total++; if (seg_lvl[2] !== 1'b1 || seg_len[2] !== 192) begin bad++; $display("FAIL rm_bit1_hi got=%b/%0d want=1/192", seg_lvl[2], seg_len[2]); end
        k = 0;
        while (done !== 1'b1 && k < 200) begin tick; k++; end
        total++; if (k !== 20) begin bad++; $display("FAIL rm_rerun_done got=%0d want=20", k); end
    endtask

    initial begin
        test_reset;
        test_zero_len;
        test_tx_only;
        test_reply;
        test_timeout;
        test_width_thresh;
        test_stall_port2;
        test_reset_mid;
        total++;
        if (stuck !== 0) begin bad++; $display("FAIL wait_bound got=%0d want=0", stuck); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=expired want=finish");
        $fatal(1, "watchdog");
    end

endmodule
